// File: rtl/sub_pipeline_generate_pkg.sv
// Shared defaults and stage-count helper for the subtractor pipeline and adder chain.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
`ifndef SUB_PIPE_CEIL_DIV
`define SUB_PIPE_CEIL_DIV(n, d) (((n) + (d) - 1) / (d))
`endif

package sub_pipeline_generate_pkg;

    localparam int SUB_PIPE_WIDTH_DEFAULT = 8;
    localparam int SUB_PIPE_CHUNK_DEFAULT = 4;

    // Exclusive upper bit index of chunk k; the last chunk is clipped to the operand width.
    function automatic int chunk_hi(input int k, input int chunk, input int width);
        int hi;
        hi = (k + 1) * chunk;
        if (hi > width) begin
            hi = width;
        end
        return hi;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a0 - a1 - b0, borrow out on b1.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline owns flow control.
module full_subtractor (
    input  logic a0,
    input  logic a1,
    input  logic b0,
    output logic d,
    output logic b1
);

    assign d  = a0 ^ a1 ^ b0;
    assign b1 = (~a0 & a1) | (~(a0 ^ a1) & b0);

endmodule

// File: rtl/sub_pipeline_generate.sv
// Pipelined ripple-borrow subtractor diff = a0 - a1, borrow in diff[WIDTH]; clamp to zero when SUB_PIPE_SATURATE_EN is defined.
// Latency: STAGES = ceil(WIDTH/CHUNK) register stages, one result per cycle.
// Backpressure: all stages advance together on adv = ~out_valid | out_ready; in_ready = adv.
module sub_pipeline_generate
    import sub_pipeline_generate_pkg::*;
#(
    parameter int WIDTH = SUB_PIPE_WIDTH_DEFAULT,
    parameter int CHUNK = SUB_PIPE_CHUNK_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff
);

    localparam int STAGES = `SUB_PIPE_CEIL_DIV(WIDTH, CHUNK);

    // Single enable for the whole pipe: bubbles are carried, never collapsed.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    genvar k, j;
    for (k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * CHUNK;
        localparam int HI  = chunk_hi(k, CHUNK, WIDTH);
        localparam int CW  = HI - LO;
        localparam int REM = WIDTH - HI;

        logic [CW-1:0] ca0;
        logic [CW-1:0] ca1;
        logic [CW-1:0] cd;
        logic [CW:0]   cb;
        logic [HI-1:0] dif_raw;
        logic [HI-1:0] dif_d;
        logic [HI-1:0] dif_q;
        logic          vld_d;
        logic          vld_q;
        logic          bor_d;
        logic          bor_q;

        // Chunk operands, incoming borrow and already-resolved bits come from the
        // inputs for stage 0 and from the previous stage register otherwise.
        if (k == 0) begin : g_src_in
            assign ca0     = a0[CW-1:0];
            assign ca1     = a1[CW-1:0];
            assign cb[0]   = 1'b0;
            assign vld_d   = in_valid;
            assign dif_raw = cd;
        end else begin : g_src_prev
            assign ca0     = g_stage[k-1].g_ops.opa_q[CW-1:0];
            assign ca1     = g_stage[k-1].g_ops.opb_q[CW-1:0];
            assign cb[0]   = g_stage[k-1].bor_q;
            assign vld_d   = g_stage[k-1].vld_q;
            assign dif_raw = {cd, g_stage[k-1].dif_q};
        end

        for (j = 0; j < CW; j++) begin : g_bit
            full_subtractor u_fs (
                .a0 (ca0[j]),
                .a1 (ca1[j]),
                .b0 (cb[j]),
                .d  (cd[j]),
                .b1 (cb[j+1])
            );
        end

        assign bor_d = cb[CW];

        // Only the output stage can clamp; earlier stages pass their bits through.
        if (k == STAGES - 1) begin : g_out
`ifdef SUB_PIPE_SATURATE_EN
            assign dif_d = bor_d ? '0 : dif_raw;
`else
            assign dif_d = dif_raw;
`endif
        end else begin : g_mid
            assign dif_d = dif_raw;
        end

        // Skewed operand bits still waiting for a later chunk travel with the transaction.
        if (REM > 0) begin : g_ops
            logic [REM-1:0] opa_d;
            logic [REM-1:0] opb_d;
            logic [REM-1:0] opa_q;
            logic [REM-1:0] opb_q;

            if (k == 0) begin : g_ops_in
                assign opa_d = a0[WIDTH-1:HI];
                assign opb_d = a1[WIDTH-1:HI];
            end else begin : g_ops_prev
                assign opa_d = g_stage[k-1].g_ops.opa_q[CW +: REM];
                assign opb_d = g_stage[k-1].g_ops.opb_q[CW +: REM];
            end

            // Operand skew registers: data only, meaningless while the stage is invalid.
            always_ff @(posedge CLK) begin
                if (adv) begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

        // Stage valid/result register: cleared by reset, loads on every advance.
        always_ff @(posedge CLK) begin
            if (RST) begin
                vld_q <= 1'b0;
                dif_q <= '0;
                bor_q <= 1'b0;
            end else if (adv) begin
                vld_q <= vld_d;
                dif_q <= dif_d;
                bor_q <= bor_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign diff      = {g_stage[STAGES-1].bor_q, g_stage[STAGES-1].dif_q};

endmodule

// File: tb/tb_sub_pipeline_generate.sv
module tb_sub_pipeline_generate;

    logic       CLK = 1'b0;
    logic       RST;

    logic       iv_a, ir_a, ov_a, ordy_a;
    logic [7:0] a0_a, a1_a;
    logic [8:0] diff_a;

    logic       iv_b, ir_b, ov_b, ordy_b;
    logic [5:0] a0_b, a1_b;
    logic [6:0] diff_b;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    sub_pipeline_generate #(.WIDTH(8), .CHUNK(4)) u_dut8 (
        .CLK(CLK), .RST(RST),
        .in_valid(iv_a), .in_ready(ir_a), .a0(a0_a), .a1(a1_a),
        .out_valid(ov_a), .out_ready(ordy_a), .diff(diff_a)
    );

    sub_pipeline_generate #(.WIDTH(6), .CHUNK(4)) u_dut6 (
        .CLK(CLK), .RST(RST),
        .in_valid(iv_b), .in_ready(ir_b), .a0(a0_b), .a1(a1_b),
        .out_valid(ov_b), .out_ready(ordy_b), .diff(diff_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hand-computed expectations for a pair whose true difference is negative.
    function automatic logic [8:0] under8(input logic [8:0] wrapped);
`ifdef SUB_PIPE_SATURATE_EN
        return 9'h100 | (wrapped & 9'h000);
`else
        return wrapped;
`endif
    endfunction

    function automatic logic [6:0] ref6(input logic [5:0] x, input logic [5:0] y);
        logic [6:0] r;
        r = {1'b0, x} - {1'b0, y};
`ifdef SUB_PIPE_SATURATE_EN
        if (r[6]) r[5:0] = 6'd0;
`endif
        return r;
    endfunction

    logic [8:0] edge_exp [4];
    logic [7:0] edge_a0  [4];
    logic [7:0] edge_a1  [4];
    logic [6:0] q[$];

    initial begin
        RST = 1'b1;
        iv_a = 1'b0; ordy_a = 1'b1; a0_a = '0; a1_a = '0;
        iv_b = 1'b0; ordy_b = 1'b1; a0_b = '0; a1_b = '0;
        tick();
        tick();
        chk("reset_out_valid", {31'd0, ov_a}, 32'd0);
        chk("reset_diff", {23'd0, diff_a}, 32'd0);
        RST = 1'b0;
        tick();
        chk("reset_in_ready", {31'd0, ir_a}, 32'd1);
        chk("reset_out_valid_w6", {31'd0, ov_b}, 32'd0);

        // Basic: 200 - 55 = 145
        iv_a = 1'b1; a0_a = 8'd200; a1_a = 8'd55;
        tick();
        iv_a = 1'b0;
        chk("basic_not_yet", {31'd0, ov_a}, 32'd0);
        tick();
        chk("basic_valid", {31'd0, ov_a}, 32'd1);
        chk("basic_diff", {23'd0, diff_a}, 32'h091);
        tick();
        chk("basic_drained", {31'd0, ov_a}, 32'd0);

        // Underflow: 5 - 10
        iv_a = 1'b1; a0_a = 8'd5; a1_a = 8'd10;
        tick();
        iv_a = 1'b0;
        tick();
        chk("under_valid", {31'd0, ov_a}, 32'd1);
        chk("under_diff", {23'd0, diff_a}, {23'd0, under8(9'h1FB)});
        tick();

        // Edge values streamed back-to-back
        edge_a0[0] = 8'd0;   edge_a1[0] = 8'd0;   edge_exp[0] = 9'h000;
        edge_a0[1] = 8'd255; edge_a1[1] = 8'd255; edge_exp[1] = 9'h000;
        edge_a0[2] = 8'd0;   edge_a1[2] = 8'd255; edge_exp[2] = under8(9'h101);
        edge_a0[3] = 8'd255; edge_a1[3] = 8'd0;   edge_exp[3] = 9'h0FF;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                iv_a = 1'b1; a0_a = edge_a0[i]; a1_a = edge_a1[i];
            end else begin
                iv_a = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 4) begin
                chk($sformatf("edge%0d_valid", i - 1), {31'd0, ov_a}, 32'd1);
                chk($sformatf("edge%0d_diff", i - 1), {23'd0, diff_a}, {23'd0, edge_exp[i-1]});
            end
        end
        chk("edge_drained", {31'd0, ov_a}, 32'd0);

        // Stall with the pipe full: X=100-1, Y=50-60, Z=7-3 queued at the input
        iv_a = 1'b1; a0_a = 8'd100; a1_a = 8'd1;
        tick();
        a0_a = 8'd50; a1_a = 8'd60;
        tick();
        ordy_a = 1'b0;
        a0_a = 8'd7; a1_a = 8'd3;
        #1;
        chk("stall_in_ready_now", {31'd0, ir_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_in_ready", i), {31'd0, ir_a}, 32'd0);
            chk($sformatf("stall%0d_valid", i), {31'd0, ov_a}, 32'd1);
            chk($sformatf("stall%0d_diff", i), {23'd0, diff_a}, 32'h063);
        end
        ordy_a = 1'b1;
        tick();
        iv_a = 1'b0;
        chk("drain_y_valid", {31'd0, ov_a}, 32'd1);
        chk("drain_y_diff", {23'd0, diff_a}, {23'd0, under8(9'h1F6)});
        tick();
        chk("drain_z_valid", {31'd0, ov_a}, 32'd1);
        chk("drain_z_diff", {23'd0, diff_a}, 32'h004);
        tick();
        chk("drain_empty", {31'd0, ov_a}, 32'd0);

        // Reset with two transactions in flight and a third presented during reset
        iv_a = 1'b1; a0_a = 8'd9; a1_a = 8'd4;
        tick();
        a0_a = 8'd20; a1_a = 8'd3;
        tick();
        chk("prerst_valid", {31'd0, ov_a}, 32'd1);
        ordy_a = 1'b0;
        RST = 1'b1;
        a0_a = 8'd40; a1_a = 8'd2;
        tick();
        chk("rst_out_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_diff", {23'd0, diff_a}, 32'd0);
        RST = 1'b0;
        iv_a = 1'b0;
        ordy_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst%0d_valid", i), {31'd0, ov_a}, 32'd0);
        end

        // Uneven chunking: 0x20 - 0x01 = 0x1F
        iv_b = 1'b1; a0_b = 6'h20; a1_b = 6'h01;
        tick();
        iv_b = 1'b0;
        tick();
        chk("w6_valid", {31'd0, ov_b}, 32'd1);
        chk("w6_diff", {25'd0, diff_b}, 32'h01F);
        tick();

        // Random sweep with random downstream backpressure
        begin
            int sent = 0;
            int got  = 0;
            logic acc, cons;
            logic [6:0] exp;
            for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
                if (!iv_b && sent < 1000) begin
                    a0_b = 6'($urandom);
                    a1_b = 6'($urandom);
                    iv_b = 1'b1;
                end
                ordy_b = ($urandom_range(0, 3) != 0);
                #1;
                acc  = iv_b && ir_b;
                cons = ov_b && ordy_b;
                if (cons) begin
                    exp = (q.size() > 0) ? q.pop_front() : 7'h7F;
                    chk($sformatf("sweep%0d", got), {25'd0, diff_b}, {25'd0, exp});
                    got++;
                end
                if (acc) begin
                    q.push_back(ref6(a0_b, a1_b));
                    sent++;
                end
                tick();
                if (acc) iv_b = 1'b0;
            end
            chk("sweep_count", got, 32'd1000);
            chk("sweep_leftover", q.size(), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
